// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

  localparam int CREDIT_W = 3;
  localparam logic [CREDIT_W-1:0] CMAX = '1;

  localparam int PROD0 = 0;
  localparam int PROD1 = 1;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DISPENSE,
    CHANGE,
    REFUND
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer moves only when a grant is taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // Index of the last granted requester; 1 after reset so requester 0 wins first.
  logic last_q;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset)
      last_q <= 1'b1;
    else if (en && (gnt != 2'b00))
      last_q <= gnt[1];
  end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction controller: coin credit, round-robin product grant,
// dispense/change sequencing and cancel/timeout refunds. All outputs registered.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE0      = 3,
  parameter int PRICE1      = 5,
  parameter int DISP_CYCLES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m,
  input  logic                a,
  input  logic [1:0]          sel,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                dispense,
  output logic [1:0]          prod,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change,
  output logic                coin_reject
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam logic [CREDIT_W-1:0] P0 = CREDIT_W'(PRICE0);
  localparam logic [CREDIT_W-1:0] P1 = CREDIT_W'(PRICE1);

  state_t              state_q, state_d;
  logic [TW-1:0]       tcnt_q, tcnt_d, tcnt_inc;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [CREDIT_W-1:0] credit_d, credit_acc, change_d;
  logic                busy_d, dispense_d, change_valid_d, coin_reject_d;
  logic [1:0]          prod_d, req, gnt;
  logic [CREDIT_W:0]   sum;
  logic                coin, accept, arb_en;

  // {a, m} is already the coin value m + 2*a.
  assign coin       = m | a;
  assign sum        = {1'b0, credit} + {{(CREDIT_W-1){1'b0}}, a, m};
  assign accept     = coin && (state_q == IDLE || state_q == COLLECT) && (sum <= {1'b0, CMAX});
  assign credit_acc = accept ? sum[CREDIT_W-1:0] : credit;
  assign tcnt_inc   = tcnt_q + 1'b1;

  // Eligibility looks at the registered credit, never at a coin arriving now.
  assign req[PROD0] = sel[PROD0] && (credit >= P0);
  assign req[PROD1] = sel[PROD1] && (credit >= P1);
  assign arb_en     = (state_q == COLLECT) && !cancel;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .en    (arb_en),
    .gnt   (gnt)
  );

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_acc;
    tcnt_d         = tcnt_q;
    dcnt_d         = dcnt_q;
    price_d        = price_q;
    busy_d         = 1'b0;
    dispense_d     = 1'b0;
    prod_d         = 2'b00;
    change_valid_d = 1'b0;
    change_d       = '0;
    coin_reject_d  = coin && !accept;

    unique case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (accept) state_d = COLLECT;
      end
      COLLECT: begin
        if (cancel || (!arb_en || gnt == 2'b00) && !accept && tcnt_inc == TW'(TIMEOUT)) begin
          state_d        = REFUND;
          busy_d         = 1'b1;
          change_valid_d = 1'b1;
          change_d       = credit_acc;
          credit_d       = '0;
          tcnt_d         = '0;
        end else if (gnt != 2'b00) begin
          state_d    = DISPENSE;
          busy_d     = 1'b1;
          dispense_d = 1'b1;
          prod_d     = gnt;
          price_d    = gnt[PROD1] ? P1 : P0;
          dcnt_d     = DW'(DISP_CYCLES - 1);
          tcnt_d     = '0;
        end else if (accept) begin
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      DISPENSE: begin
        busy_d = 1'b1;
        if (dcnt_q == '0) begin
          state_d        = CHANGE;
          change_d       = credit - price_q;
          change_valid_d = (credit != price_q);
          credit_d       = '0;
        end else begin
          dcnt_d     = dcnt_q - 1'b1;
          dispense_d = 1'b1;
          prod_d     = prod;
        end
      end
      CHANGE, REFUND: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tcnt_q       <= '0;
      dcnt_q       <= '0;
      price_q      <= '0;
      credit       <= '0;
      busy         <= 1'b0;
      dispense     <= 1'b0;
      prod         <= 2'b00;
      change_valid <= 1'b0;
      change       <= '0;
      coin_reject  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      dcnt_q       <= dcnt_d;
      price_q      <= price_d;
      credit       <= credit_d;
      busy         <= busy_d;
      dispense     <= dispense_d;
      prod         <= prod_d;
      change_valid <= change_valid_d;
      change       <= change_d;
      coin_reject  <= coin_reject_d;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed literal checks plus randomized
// traffic against a transaction-level model of the sale/refund rules.
module tb_vend_controller;

  localparam int CMAX_M = 7;
  localparam int PR0 = 3, PR1 = 5, DISP = 2, TOUT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1, m = 1'b0, a = 1'b0, cancel = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [2:0] credit, change;
  logic       busy, dispense, change_valid, coin_reject;
  logic [1:0] prod;

  vend_controller dut (
    .clk          (clk),
    .reset        (reset),
    .m            (m),
    .a            (a),
    .sel          (sel),
    .cancel       (cancel),
    .credit       (credit),
    .busy         (busy),
    .dispense     (dispense),
    .prod         (prod),
    .change_valid (change_valid),
    .change       (change),
    .coin_reject  (coin_reject)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: future output cycles of a sale are queued as records; busy means the
  // previous cycle showed a sale/refund record.
  typedef struct {
    int disp;
    int prod;
    int cv;
    int chg;
    int credit;
  } rec_t;

  rec_t q[$];
  int   mc, last, idle;
  int   e_credit, e_busy, e_disp, e_prod, e_cv, e_chg, e_rej;
  bit   model_ok = 1'b0;

  always @(posedge clk) begin
    int   v, newc, g, price;
    bit   busy_now, accept, e0, e1;
    rec_t r;
    if (reset) begin
      mc = 0; last = 1; idle = 0; q.delete();
      {e_credit, e_busy, e_disp, e_prod, e_cv, e_chg, e_rej} = '0;
      model_ok = 1'b1;
    end else begin
      v        = int'(m) + 2 * int'(a);
      busy_now = (e_busy != 0);
      accept   = !busy_now && v > 0 && mc + v <= CMAX_M;
      newc     = accept ? mc + v : mc;
      e_rej    = (v > 0 && !accept) ? 1 : 0;
      e_disp = 0; e_prod = 0; e_cv = 0; e_chg = 0; e_busy = 0;
      if (busy_now) begin
        if (q.size() > 0) begin
          r = q.pop_front();
          e_disp = r.disp; e_prod = r.prod; e_cv = r.cv; e_chg = r.chg;
          e_credit = r.credit; e_busy = 1;
        end else begin
          e_credit = mc;
        end
      end else if (mc == 0) begin
        if (accept) begin mc = v; idle = 0; end
        e_credit = mc;
      end else begin
        e0 = sel[0] && mc >= PR0;
        e1 = sel[1] && mc >= PR1;
        if (cancel) begin
          e_cv = 1; e_chg = newc; e_busy = 1; e_credit = 0; mc = 0; idle = 0;
        end else if (e0 || e1) begin
          g     = (e0 && e1) ? 1 - last : (e1 ? 1 : 0);
          last  = g;
          price = g ? PR1 : PR0;
          e_disp = 1; e_prod = 1 << g; e_busy = 1; e_credit = newc;
          for (int i = 1; i < DISP; i++) q.push_back('{1, 1 << g, 0, 0, newc});
          q.push_back('{0, 0, (newc != price) ? 1 : 0, newc - price, 0});
          mc = 0; idle = 0;
        end else if (accept) begin
          mc = newc; idle = 0; e_credit = mc;
        end else begin
          idle++;
          if (idle == TOUT) begin
            e_cv = 1; e_chg = mc; e_busy = 1; e_credit = 0; mc = 0; idle = 0;
          end else begin
            e_credit = mc;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("credit",       credit,       e_credit[7:0]);
      check("busy",         busy,         e_busy[7:0]);
      check("dispense",     dispense,     e_disp[7:0]);
      check("prod",         prod,         e_prod[7:0]);
      check("change_valid", change_valid, e_cv[7:0]);
      check("change",       change,       e_chg[7:0]);
      check("coin_reject",  coin_reject,  e_rej[7:0]);
    end
  end

  task automatic cyc(input logic mm, input logic aa, input logic [1:0] ss,
                     input logic cc, input logic rr = 1'b0);
    m = mm; a = aa; sel = ss; cancel = cc; reset = rr;
    @(negedge clk);
    m = 1'b0; a = 1'b0; cancel = 1'b0; reset = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 2'b00, 0);
  endtask

  initial begin
    int coin_div;
    cyc(0, 0, 2'b00, 0, 1);
    cyc(0, 0, 2'b00, 0, 1);
    check("reset_credit", credit, 8'd0);
    check("reset_busy", busy, 8'd0);

    // Exact sale of product 0 from credit 4.
    cyc(0, 1, 2'b00, 0);
    cyc(0, 1, 2'b00, 0);
    check("sale_credit4", credit, 8'd4);
    cyc(0, 0, 2'b01, 0);
    check("sale_disp1", dispense, 8'd1);
    check("sale_prod", prod, 8'd1);
    cyc(0, 0, 2'b00, 0);
    check("sale_disp2", dispense, 8'd1);
    cyc(0, 0, 2'b00, 0);
    check("sale_disp_off", dispense, 8'd0);
    check("sale_cv", change_valid, 8'd1);
    check("sale_change", change, 8'd1);
    check("sale_credit0", credit, 8'd0);
    idle_cycles(1);

    // Saturation at CMAX.
    cyc(0, 1, 2'b00, 0); cyc(0, 1, 2'b00, 0); cyc(0, 1, 2'b00, 0);
    cyc(0, 1, 2'b00, 0);
    check("sat_reject", coin_reject, 8'd1);
    check("sat_credit6", credit, 8'd6);
    cyc(1, 0, 2'b00, 0);
    check("sat_credit7", credit, 8'd7);
    check("sat_no_reject", coin_reject, 8'd0);
    cyc(0, 0, 2'b00, 1);
    check("sat_refund", change, 8'd7);
    idle_cycles(1);

    // Round-robin from a fresh pointer.
    cyc(0, 0, 2'b00, 0, 1);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, 2'b00, 0); cyc(0, 1, 2'b00, 0); cyc(0, 1, 2'b00, 0); cyc(1, 0, 2'b00, 0);
      cyc(0, 0, 2'b11, 0);
      check("arb_prod", prod, (k == 0) ? 8'd1 : 8'd2);
      cyc(0, 0, 2'b00, 0);
      cyc(0, 0, 2'b00, 0);
      check("arb_change", change, (k == 0) ? 8'd4 : 8'd2);
      idle_cycles(1);
    end

    // Timeout refund, plain and with a coin restarting the count.
    cyc(1, 0, 2'b00, 0);
    idle_cycles(14);
    check("tout_pending", change_valid, 8'd0);
    idle_cycles(1);
    check("tout_cv", change_valid, 8'd1);
    check("tout_change", change, 8'd1);
    idle_cycles(1);
    cyc(1, 0, 2'b00, 0);
    idle_cycles(9);
    cyc(1, 0, 2'b00, 0);
    idle_cycles(14);
    check("tout2_pending", credit, 8'd2);
    idle_cycles(1);
    check("tout2_change", change, 8'd2);
    idle_cycles(1);

    // Cancel beats an eligible request.
    cyc(0, 1, 2'b00, 0); cyc(0, 1, 2'b00, 0); cyc(1, 0, 2'b00, 0);
    cyc(0, 0, 2'b10, 1);
    check("prio_no_disp", dispense, 8'd0);
    check("prio_refund", change, 8'd5);
    idle_cycles(1);

    // Coin while dispensing is rejected and does not touch the change.
    cyc(0, 1, 2'b00, 0); cyc(0, 1, 2'b00, 0); cyc(1, 0, 2'b00, 0);
    cyc(0, 0, 2'b10, 0);
    check("busy_prod1", prod, 8'd2);
    cyc(1, 0, 2'b00, 0);
    check("busy_reject", coin_reject, 8'd1);
    cyc(0, 0, 2'b00, 0);
    check("busy_cv", change_valid, 8'd0);
    check("busy_change", change, 8'd0);
    idle_cycles(1);

    // Reset during dispense.
    cyc(0, 1, 2'b00, 0); cyc(1, 0, 2'b00, 0);
    cyc(0, 0, 2'b01, 0);
    cyc(0, 0, 2'b00, 0, 1);
    check("rst_disp", dispense, 8'd0);
    check("rst_prod", prod, 8'd0);
    check("rst_credit", credit, 8'd0);
    check("rst_cv", change_valid, 8'd0);
    idle_cycles(2);

    // Randomized traffic, alternating busy and quiet phases.
    coin_div = 3;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) coin_div = ($urandom_range(0, 1) != 0) ? 3 : 40;
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
      m      = ($urandom_range(0, coin_div - 1) == 0);
      a      = ($urandom_range(0, coin_div - 1) == 0);
      cancel = ($urandom_range(0, 59) == 0);
      reset  = ($urandom_range(0, 699) == 0);
      @(negedge clk);
    end
    m = 1'b0; a = 1'b0; cancel = 1'b0; reset = 1'b0; sel = 2'b00;
    idle_cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
